card_match_ctrl: RTL and testbench
==================================

CARD_MATCH_CTRL -- requirements
Module: card_match_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 25000000, cycles a mismatched pair stays face-up (bench overrides to 4).
REQ-002 SHALL have parameter NUM_PAIRS, default 8, pairs per board (16 cards).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load  input  1  latch card_values and start a new game.
REQ-006 SHALL have port card_values  input  [0:47]  card i value is bits [3i:3i+2], MSB-first, from the shuffle stage.
REQ-007 SHALL have port flip_req  input  1  one-cycle request to turn card flip_idx.
REQ-008 SHALL have port flip_idx  input  4  card index 0..15.
REQ-009 SHALL have port face_up  output  16  unmatched cards currently shown; bit i = card i.
REQ-010 SHALL have port matched  output  16  cards removed as matched pairs.
REQ-011 SHALL have port pair_count  output  4  pairs matched this game, 0..8.
REQ-012 SHALL have port moves  output  8  completed pair attempts, saturating at 255.
REQ-013 SHALL have port match_pulse  output  1  one-cycle strobe on a successful match.
REQ-014 SHALL have port busy  output  1  high in COMPARE and SHOW_MISMATCH.
REQ-015 SHALL have port game_over  output  1  high in DONE.

Function
REQ-016 SHALL implement states IDLE, WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW_MISMATCH, DONE.
REQ-017 SHALL, on load in any state, latch card_values, clear face_up, matched, pair_count, moves, and enter WAIT_FIRST on the next cycle.
REQ-018 SHALL give load priority over a simultaneous flip_req; that flip_req is dropped.
REQ-019 SHALL ignore flip_req in IDLE, COMPARE, SHOW_MISMATCH and DONE, and for a card already face-up or matched.
REQ-020 SHALL, on an accepted flip_req in WAIT_FIRST, record first index, set its face_up bit next cycle, and enter WAIT_SECOND.
REQ-021 SHALL, on an accepted flip_req in WAIT_SECOND, record second index, set its face_up bit next cycle, and enter COMPARE.
REQ-022 SHALL spend exactly one cycle in COMPARE, comparing the two latched 3-bit values.
REQ-023 SHALL, on equal values, set both matched bits, clear both face_up bits, increment pair_count and moves, assert match_pulse one cycle, then enter WAIT_FIRST, or DONE if pair_count reaches NUM_PAIRS.
REQ-024 SHALL, on unequal values, increment moves, enter SHOW_MISMATCH, and hold both cards face-up for exactly HOLD_CYCLES cycles.
REQ-025 SHALL, after the SHOW_MISMATCH hold, clear both face_up bits and enter WAIT_FIRST.
REQ-026 SHALL hold moves at 255 once reached; further attempts do not wrap it.
REQ-027 SHALL keep all outputs stable in DONE until load or reset.

Reset
REQ-028 SHALL, with reset high at a clock edge, enter IDLE and drive face_up=0, matched=0, pair_count=0, moves=0, match_pulse=0, busy=0, game_over=0.
REQ-029 SHALL give reset priority over load and flip_req, including mid-SHOW_MISMATCH, where the hold counter is cleared.

Structure
REQ-030 SHALL place state encoding, NUM_CARDS=16, CARD_W=3 and the card-field extraction function in the shared game package.
REQ-031 SHALL implement the SHOW_MISMATCH timer as sub-module hold_timer (start, done, parameter HOLD_CYCLES).

Verification
REQ-032 SHALL test reset then flip_req idx 0 -> no state change, face_up=0.
REQ-033 SHALL test load with card 0=3, card 5=3, then flip 0 and flip 5 -> match_pulse one cycle, matched=16'h0021, pair_count=1, moves=1.
REQ-034 SHALL test card 1=2, card 2=6, flip 1, flip 2, HOLD_CYCLES=4 -> face_up=16'h0006 for exactly 4 cycles, then 0, moves+1, busy high throughout.
REQ-035 SHALL test flip of a face-up or matched card, and flip during busy -> ignored, counters unchanged.
REQ-036 SHALL test load during SHOW_MISMATCH, and load coincident with flip_req -> WAIT_FIRST next cycle, all counters 0, flip dropped.
REQ-037 SHALL test solving all 8 pairs -> game_over high after the 8th match_pulse, pair_count=8, further flips ignored.

Source files
------------

// File: rtl/card_match_ctrl_pkg.sv
// Shared definitions for the memory-card game: FSM encoding, board geometry
// and the helper that pulls one card value out of the packed board vector.
package card_match_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FIRST,
    ST_WAIT_SECOND,
    ST_COMPARE,
    ST_SHOW_MISMATCH,
    ST_DONE
  } state_t;

  localparam int NUM_CARDS = 16;
  localparam int CARD_W    = 3;

  // Card i occupies bits [3i:3i+2] of an ascending vector, first bit is the MSB.
  function automatic logic [CARD_W-1:0] card_field(
    input logic [0:NUM_CARDS*CARD_W-1] vals,
    input logic [3:0]                  idx
  );
    logic [CARD_W-1:0] f;
    logic [5:0]        pos;
    f = '0;
    for (int b = 0; b < CARD_W; b++) begin
      pos = 6'(idx) * 6'(CARD_W) + 6'(b);
      f[CARD_W-1-b] = vals[pos];
    end
    return f;
  endfunction

endpackage

// File: rtl/card_match_ctrl_hold_timer.sv
// One-shot hold timer: done is high in the last of HOLD_CYCLES cycles after start.
// Latency HOLD_CYCLES cycles from start; no backpressure, a new start restarts it.
module hold_timer #(
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  logic [CW-1:0] cnt;
  logic          active;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= CW'(HOLD_CYCLES - 1);
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - CW'(1);
    end
  end

  assign done = active && (cnt == '0);

endmodule

// File: rtl/card_match_ctrl.sv
// Memory-card game controller: takes two flips, compares them, scores matches.
// Flip results appear the next cycle; flips are dropped (not queued) while busy.
module card_match_ctrl
  import card_match_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 25000000,
  parameter int NUM_PAIRS   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [0:NUM_CARDS*CARD_W-1]   card_values,
  input  logic                          flip_req,
  input  logic [3:0]                    flip_idx,
  output logic [NUM_CARDS-1:0]          face_up,
  output logic [NUM_CARDS-1:0]          matched,
  output logic [3:0]                    pair_count,
  output logic [7:0]                    moves,
  output logic                          match_pulse,
  output logic                          busy,
  output logic                          game_over
);

  state_t                        state, state_nxt;
  logic [0:NUM_CARDS*CARD_W-1]   vals;
  logic [3:0]                    first_idx, second_idx;
  logic                          accept, is_equal, last_pair;
  logic                          tmr_start, tmr_done;
  logic [NUM_CARDS-1:0]          pick_mask;
  logic [7:0]                    moves_inc;

  assign accept = flip_req && !load && !face_up[flip_idx] && !matched[flip_idx] &&
                  (state == ST_WAIT_FIRST || state == ST_WAIT_SECOND);
  assign is_equal  = card_field(vals, first_idx) == card_field(vals, second_idx);
  assign last_pair = pair_count == 4'(NUM_PAIRS - 1);
  assign pick_mask = (16'd1 << first_idx) | (16'd1 << second_idx);
  assign moves_inc = (moves == 8'hFF) ? moves : moves + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = ST_WAIT_FIRST;
    end else begin
      case (state)
        ST_WAIT_FIRST:    if (accept) state_nxt = ST_WAIT_SECOND;
        ST_WAIT_SECOND:   if (accept) state_nxt = ST_COMPARE;
        ST_COMPARE:       state_nxt = is_equal ? (last_pair ? ST_DONE : ST_WAIT_FIRST)
                                               : ST_SHOW_MISMATCH;
        ST_SHOW_MISMATCH: if (tmr_done) state_nxt = ST_WAIT_FIRST;
        default:          state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy      = (state == ST_COMPARE) || (state == ST_SHOW_MISMATCH);
    game_over = (state == ST_DONE);
    tmr_start = (state == ST_COMPARE) && !is_equal && !load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vals        <= '0;
      first_idx   <= '0;
      second_idx  <= '0;
      face_up     <= '0;
      matched     <= '0;
      pair_count  <= '0;
      moves       <= '0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= 1'b0;
      if (load) begin
        vals       <= card_values;
        face_up    <= '0;
        matched    <= '0;
        pair_count <= '0;
        moves      <= '0;
      end else begin
        case (state)
          ST_WAIT_FIRST: if (accept) begin
            first_idx <= flip_idx;
            face_up   <= face_up | (16'd1 << flip_idx);
          end
          ST_WAIT_SECOND: if (accept) begin
            second_idx <= flip_idx;
            face_up    <= face_up | (16'd1 << flip_idx);
          end
          ST_COMPARE: begin
            moves <= moves_inc;
            if (is_equal) begin
              matched     <= matched | pick_mask;
              face_up     <= face_up & ~pick_mask;
              pair_count  <= pair_count + 4'd1;
              match_pulse <= 1'b1;
            end
          end
          ST_SHOW_MISMATCH: if (tmr_done) face_up <= face_up & ~pick_mask;
          default: ;
        endcase
      end
    end
  end

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .start (tmr_start),
    .done  (tmr_done)
  );

endmodule

// File: tb/tb_card_match_ctrl.sv
// Bench for card_match_ctrl: per-cycle vectors with expected outputs queued as
// stimulus is driven and checked one clock later.
module tb_card_match_ctrl;

  logic        clk = 1'b0;
  logic        reset, load, flip_req;
  logic [0:47] card_values;
  logic [3:0]  flip_idx;
  logic [15:0] face_up, matched;
  logic [3:0]  pair_count;
  logic [7:0]  moves;
  logic        match_pulse, busy, game_over;

  card_match_ctrl #(.HOLD_CYCLES(4), .NUM_PAIRS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .card_values (card_values),
    .flip_req    (flip_req),
    .flip_idx    (flip_idx),
    .face_up     (face_up),
    .matched     (matched),
    .pair_count  (pair_count),
    .moves       (moves),
    .match_pulse (match_pulse),
    .busy        (busy),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        fr;
    logic [3:0]  idx;
    logic [15:0] fu;
    logic [15:0] mt;
    logic [3:0]  pc;
    logic [7:0]  mv;
    logic        mp;
    logic        bz;
    logic        go;
  } vec_t;

  vec_t        sb[$];
  vec_t        tbl[14];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          step_no  = 0;
  logic [0:47] board_cv;
  logic [2:0]  board [16] = '{3, 2, 6, 0, 1, 3, 4, 5, 7, 0, 1, 2, 4, 5, 6, 7};
  int          pa [8] = '{0, 1, 2, 3, 4, 6, 7, 8};
  int          pb [8] = '{5, 11, 14, 9, 10, 12, 13, 15};
  logic [15:0] m_mt;
  int          m_pc, m_mv;

  function automatic vec_t mk(input bit ld, input bit fr, input int idx, input logic [15:0] fu,
                              input logic [15:0] mt, input int pc, input int mv,
                              input bit mp, input bit bz, input bit go);
    vec_t v;
    v.ld = ld; v.fr = fr; v.idx = 4'(idx); v.fu = fu; v.mt = mt;
    v.pc = 4'(pc); v.mv = 8'(mv); v.mp = mp; v.bz = bz; v.go = go;
    return v;
  endfunction

  function automatic logic [15:0] oh(input int i);
    logic [15:0] one;
    one = 16'd1;
    return one << i;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h want 0x%0h", name, step_no, act, exp);
    end
  endtask

  // Board values are only presented on load cycles; otherwise all-zero, so a
  // design that compares live inputs instead of the latched board is caught.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    load        = v.ld;
    flip_req    = v.fr;
    flip_idx    = v.idx;
    card_values = v.ld ? board_cv : '0;
    sb.push_back(v);
    @(posedge clk);
    #1;
    step_no++;
    e = sb.pop_front();
    chk("face_up",     face_up,               e.fu);
    chk("matched",     matched,               e.mt);
    chk("pair_count",  16'(pair_count),       16'(e.pc));
    chk("moves",       16'(moves),            16'(e.mv));
    chk("match_pulse", 16'(match_pulse),      16'(e.mp));
    chk("busy",        16'(busy),             16'(e.bz));
    chk("game_over",   16'(game_over),        16'(e.go));
  endtask

  task automatic do_load();
    step(mk(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0));
    m_mt = '0; m_pc = 0; m_mv = 0;
  endtask

  task automatic do_match(input int a, input int b);
    step(mk(0, 1, a, oh(a), m_mt, m_pc, m_mv, 0, 0, 0));
    step(mk(0, 1, b, oh(a) | oh(b), m_mt, m_pc, m_mv, 0, 1, 0));
    m_mt = m_mt | oh(a) | oh(b);
    m_pc++;
    m_mv = (m_mv >= 255) ? 255 : m_mv + 1;
    step(mk(0, 0, 0, 16'h0, m_mt, m_pc, m_mv, 1, 0, m_pc == 8));
  endtask

  // Both cards must stay up for exactly four cycles of SHOW_MISMATCH.
  task automatic do_mismatch(input int a, input int b);
    step(mk(0, 1, a, oh(a), m_mt, m_pc, m_mv, 0, 0, 0));
    step(mk(0, 1, b, oh(a) | oh(b), m_mt, m_pc, m_mv, 0, 1, 0));
    m_mv = (m_mv >= 255) ? 255 : m_mv + 1;
    for (int k = 0; k < 4; k++)
      step(mk(0, 1, 9, oh(a) | oh(b), m_mt, m_pc, m_mv, 0, 1, 0));
    step(mk(0, 0, 0, 16'h0, m_mt, m_pc, m_mv, 0, 0, 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at step %0d", step_no);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      board_cv[3*i]   = board[i][2];
      board_cv[3*i+1] = board[i][1];
      board_cv[3*i+2] = board[i][0];
    end
    // From WAIT_FIRST with a fresh board: match 0/5, then mismatch 1/2.
    tbl[0]  = mk(0, 1, 0, 16'h0001, 16'h0000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 16'h0001, 16'h0000, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 5, 16'h0021, 16'h0000, 0, 0, 0, 1, 0);
    tbl[3]  = mk(0, 1, 7, 16'h0000, 16'h0021, 1, 1, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 16'h0000, 16'h0021, 1, 1, 0, 0, 0);
    tbl[5]  = mk(0, 1, 5, 16'h0000, 16'h0021, 1, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 16'h0002, 16'h0021, 1, 1, 0, 0, 0);
    tbl[7]  = mk(0, 1, 2, 16'h0006, 16'h0021, 1, 1, 0, 1, 0);
    tbl[8]  = mk(0, 1, 3, 16'h0006, 16'h0021, 1, 2, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 16'h0006, 16'h0021, 1, 2, 0, 1, 0);
    tbl[10] = mk(0, 1, 4, 16'h0006, 16'h0021, 1, 2, 0, 1, 0);
    tbl[11] = mk(0, 0, 0, 16'h0006, 16'h0021, 1, 2, 0, 1, 0);
    tbl[12] = mk(0, 0, 0, 16'h0000, 16'h0021, 1, 2, 0, 0, 0);
    tbl[13] = mk(0, 1, 3, 16'h0008, 16'h0021, 1, 2, 0, 0, 0);

    reset = 1'b1; load = 1'b0; flip_req = 1'b0; flip_idx = '0; card_values = '0;
    step(mk(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0));
    step(mk(1, 1, 3, 16'h0, 16'h0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    step(mk(0, 1, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0));

    do_load();
    foreach (tbl[i]) step(tbl[i]);

    // Card 3 is up in WAIT_SECOND; mismatch with 4, then load mid-hold.
    step(mk(0, 1, 4, 16'h0018, 16'h0021, 1, 2, 0, 1, 0));
    step(mk(0, 0, 0, 16'h0018, 16'h0021, 1, 3, 0, 1, 0));
    step(mk(0, 0, 0, 16'h0018, 16'h0021, 1, 3, 0, 1, 0));
    step(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0));
    step(mk(1, 1, 6, 16'h0000, 16'h0000, 0, 0, 0, 0, 0));
    step(mk(0, 1, 6, 16'h0040, 16'h0000, 0, 0, 0, 0, 0));

    do_load();
    for (int p = 0; p < 8; p++) do_match(pa[p], pb[p]);
    step(mk(0, 1, 2, 16'h0, 16'hFFFF, 8, 8, 0, 0, 1));
    step(mk(0, 0, 0, 16'h0, 16'hFFFF, 8, 8, 0, 0, 1));

    do_load();
    for (int k = 0; k < 257; k++) do_mismatch(0, 1);

    // Reset in the middle of a hold, then check the next hold is full length.
    step(mk(0, 1, 3, 16'h0008, 16'h0, 0, 255, 0, 0, 0));
    step(mk(0, 1, 4, 16'h0018, 16'h0, 0, 255, 0, 1, 0));
    step(mk(0, 0, 0, 16'h0018, 16'h0, 0, 255, 0, 1, 0));
    reset = 1'b1;
    step(mk(1, 1, 2, 16'h0, 16'h0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    step(mk(0, 1, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0));
    do_load();
    do_mismatch(3, 4);
    do_match(3, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
